// File: rtl/inst_prefetch_pkg.sv
// Shared sizing defaults and helpers for the instruction prefetch stage.
package inst_prefetch_pkg;

  localparam int          DEPTH_DEF    = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  // One extra bit beyond the index distinguishes a full ring from an empty one.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/prefetch_slot_buf.sv
// Purpose: ring of fetch slots (pc, inst, filled) with alloc/fill/read pointers.
// Latency: writes are registered; head fields reflect the slot at read combinationally.
// Backpressure: none internally; the caller's credit check keeps alloc from overrunning read.
module prefetch_slot_buf import inst_prefetch_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc,
  input  logic [31:0]   alloc_pc,
  input  logic          fill,
  input  logic [31:0]   fill_inst,
  input  logic          pop,
  input  logic          flush,
  output logic [PW-1:0] used,
  output logic [PW-1:0] pending,
  output logic          head_filled,
  output logic [31:0]   head_pc,
  output logic [31:0]   head_inst
);

  logic [PW-1:0]    alloc_ptr, fill_ptr, read_ptr;
  logic [PW-2:0]    a_idx, f_idx, r_idx;
  logic [DEPTH-1:0] filled;
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      inst_q [DEPTH];

  assign a_idx = alloc_ptr[PW-2:0];
  assign f_idx = fill_ptr[PW-2:0];
  assign r_idx = read_ptr[PW-2:0];

  assign used        = alloc_ptr - read_ptr;
  assign pending     = alloc_ptr - fill_ptr;
  assign head_filled = filled[r_idx];
  assign head_pc     = pc_q[r_idx];
  assign head_inst   = inst_q[r_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      read_ptr  <= '0;
      filled    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= NOP_INST;
      end
    end else if (flush) begin
      alloc_ptr <= read_ptr;
      fill_ptr  <= read_ptr;
      filled    <= '0;
    end else begin
      if (alloc) begin
        pc_q[a_idx]   <= alloc_pc;
        filled[a_idx] <= 1'b0;
        alloc_ptr     <= alloc_ptr + PW'(1);
      end
      if (fill) begin
        inst_q[f_idx] <= fill_inst;
        filled[f_idx] <= 1'b1;
        fill_ptr      <= fill_ptr + PW'(1);
      end
      if (pop) begin
        filled[r_idx] <= 1'b0;
        read_ptr      <= read_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/inst_prefetch.sv
// Purpose: sequential instruction prefetch with redirect flush between imem and decode.
// Latency: response to out_valid is 1 cycle; first request in the cycle after reset or redirect.
// Backpressure: requests stall while buffered plus in-flight (including discards) reach DEPTH.
module inst_prefetch import inst_prefetch_pkg::*; #(
  parameter int          DEPTH    = DEPTH_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int            PW      = ptr_w(DEPTH);
  localparam logic [PW:0]   DEPTH_W = (PW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [PW-1:0] drop_cnt;
  logic [PW-1:0] used, pending;
  logic          head_filled;
  logic [31:0]   head_pc, head_inst;
  logic [PW:0]   credit_used, inflight;
  logic          req_fire, out_fire, resp_keep;

  assign credit_used    = {1'b0, used} + {1'b0, drop_cnt};
  assign imem_req_valid = !rst && (credit_used < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign out_valid = !rst && head_filled && (used != '0);
  assign out_pc    = rst ? '0 : head_pc;
  assign out_inst  = rst ? '0 : head_inst;
  assign out_fire  = out_valid && out_ready;

  assign resp_keep = imem_resp_valid && (drop_cnt == '0) && !redirect;

  // Everything accepted by memory but not yet answered, as it stands after this cycle.
  assign inflight = {1'b0, pending} + {1'b0, drop_cnt}
                  + (PW+1)'(req_fire) - (PW+1)'(imem_resp_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~32'd3;
      drop_cnt <= inflight[PW-1:0];
    end else begin
      if (req_fire)
        fetch_pc <= fetch_pc + 32'd4;
      if (imem_resp_valid && (drop_cnt != '0))
        drop_cnt <= drop_cnt - PW'(1);
    end
  end

  prefetch_slot_buf #(.DEPTH(DEPTH), .PW(PW)) u_slots (
    .clk         (clk),
    .rst         (rst),
    .alloc       (req_fire && !redirect),
    .alloc_pc    (fetch_pc),
    .fill        (resp_keep),
    .fill_inst   (imem_resp_data),
    .pop         (out_fire && !redirect),
    .flush       (redirect),
    .used        (used),
    .pending     (pending),
    .head_filled (head_filled),
    .head_pc     (head_pc),
    .head_inst   (head_inst)
  );

  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    credit_used <= DEPTH_W);
  a_resp_has_owner: assert property (@(posedge clk) disable iff (rst)
    !(imem_resp_valid && (drop_cnt == '0) && (pending == '0)));

endmodule
